// File: rtl/vga_timing_radius_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_radius_gen
//
// Purpose
//   Upstream stage of the VGA effect pipeline. Generates 640x480@60 raster
//   timing (800x525 total, 25.175 MHz pixel clock by default), the current
//   pixel coordinate, a completed-frame counter and line/frame strobes.
//   It also produces the exact squared distance of the current pixel from
//   a per-frame centre. The distance is built incrementally, with adders
//   only and no multiplier.
//
// Optional feature (compile-time macro)
//   VGA_TIMING_RADIUS_EN
//     defined   : centre latch, shift-add squaring FSM and incremental
//                 radius datapath are built.
//     undefined : that logic is omitted, r2_o is tied to 0 and cx_i/cy_i
//                 are ignored. Timing, strobes and frame_o are unchanged.
//
// Ports
//   clk           in   pixel clock
//   rst_n         in   asynchronous active-low reset
//   cx_i [9:0]    in   radius centre X, latched at the start of vblank
//   cy_i [9:0]    in   radius centre Y, latched at the start of vblank
//   hsync_o       out  active-low horizontal sync
//   vsync_o       out  active-low vertical sync
//   display_on_o  out  high inside the visible region
//   hpos_o [9:0]  out  current column
//   vpos_o [9:0]  out  current line
//   line_start_o  out  high while hpos == 0
//   frame_start_o out  high while hpos == 0 and vpos == 0
//   frame_o       out  completed-frame count, wraps modulo 2^FRAME_W
//   r2_o [20:0]   out  (hpos-cx)^2 + (vpos-cy)^2 while display_on, else 0
// ---------------------------------------------------------------------------
module vga_timing_radius_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int FRAME_W   = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [9:0]         cx_i,
    input  logic [9:0]         cy_i,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic               display_on_o,
    output logic [9:0]         hpos_o,
    output logic [9:0]         vpos_o,
    output logic               line_start_o,
    output logic               frame_start_o,
    output logic [FRAME_W-1:0] frame_o,
    output logic [20:0]        r2_o
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    // Sized copies of the decode thresholds so every compare is 10 bits wide.
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS      = 10'(V_DISPLAY);
    localparam logic [9:0] HS_FIRST   = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_LAST    = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_LAST    = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    // -----------------------------------------------------------------------
    // Raster counters
    // -----------------------------------------------------------------------
    logic [9:0]         hpos_q, hpos_d;
    logic [9:0]         vpos_q, vpos_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               h_last;
    logic               v_last;

    assign h_last = (hpos_q == H_LAST);
    assign v_last = (vpos_q == V_LAST);

    always_comb begin
        hpos_d  = h_last ? 10'd0 : hpos_q + 10'd1;
        vpos_d  = vpos_q;
        frame_d = frame_q;
        if (h_last) begin
            vpos_d = v_last ? 10'd0 : vpos_q + 10'd1;
            if (v_last) begin
                frame_d = frame_q + FRAME_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hpos_q  <= '0;
            vpos_q  <= '0;
            frame_q <= '0;
        end else begin
            hpos_q  <= hpos_d;
            vpos_q  <= vpos_d;
            frame_q <= frame_d;
        end
    end

    // Decoded outputs come straight off the registered counters, so they are
    // aligned with hpos_o/vpos_o in the same cycle.
    assign hpos_o        = hpos_q;
    assign vpos_o        = vpos_q;
    assign frame_o       = frame_q;
    assign hsync_o       = !((hpos_q >= HS_FIRST) && (hpos_q <= HS_LAST));
    assign vsync_o       = !((vpos_q >= VS_FIRST) && (vpos_q <= VS_LAST));
    assign display_on_o  = (hpos_q < H_VIS) && (vpos_q < V_VIS);
    assign line_start_o  = (hpos_q == 10'd0);
    assign frame_start_o = (hpos_q == 10'd0) && (vpos_q == 10'd0);

`ifdef VGA_TIMING_RADIUS_EN
    // -----------------------------------------------------------------------
    // Centre latch and shift-add squaring
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE,
        SQ_X,
        SQ_Y,
        DONE
    } sq_state_e;

    sq_state_e   sq_state_q, sq_state_d;
    logic [9:0]  cxl_q, cxl_d;
    logic [9:0]  cyl_q, cyl_d;
    logic [19:0] cx2_q, cx2_d;
    logic [19:0] cy2_q, cy2_d;
    logic [19:0] sq_acc_q, sq_acc_d;
    logic [3:0]  sq_cnt_q, sq_cnt_d;
    logic [9:0]  sq_op;
    logic [19:0] sq_term;
    logic [19:0] sq_sum;
    logic        latch_now;

    // First line of vblank: the visible frame has just ended, so the new
    // centre and its squares have the whole blanking interval to settle.
    assign latch_now = (hpos_q == 10'd0) && (vpos_q == V_VIS);

    // One partial product per step: add op << k when bit k of op is set.
    assign sq_op   = (sq_state_q == SQ_Y) ? cyl_q : cxl_q;
    assign sq_term = sq_op[sq_cnt_q] ? ({10'd0, sq_op} << sq_cnt_q) : 20'd0;
    assign sq_sum  = sq_acc_q + sq_term;

    always_comb begin
        sq_state_d = sq_state_q;
        cxl_d      = cxl_q;
        cyl_d      = cyl_q;
        cx2_d      = cx2_q;
        cy2_d      = cy2_q;
        sq_acc_d   = sq_acc_q;
        sq_cnt_d   = sq_cnt_q;

        if (latch_now) begin
            cxl_d = cx_i;
            cyl_d = cy_i;
        end

        case (sq_state_q)
            IDLE: begin
                if (latch_now) begin
                    sq_state_d = SQ_X;
                    sq_acc_d   = '0;
                    sq_cnt_d   = '0;
                end
            end
            SQ_X: begin
                if (sq_cnt_q == 4'd9) begin
                    cx2_d      = sq_sum;
                    sq_acc_d   = '0;
                    sq_cnt_d   = '0;
                    sq_state_d = SQ_Y;
                end else begin
                    sq_acc_d = sq_sum;
                    sq_cnt_d = sq_cnt_q + 4'd1;
                end
            end
            SQ_Y: begin
                if (sq_cnt_q == 4'd9) begin
                    cy2_d      = sq_sum;
                    sq_acc_d   = '0;
                    sq_cnt_d   = '0;
                    sq_state_d = DONE;
                end else begin
                    sq_acc_d = sq_sum;
                    sq_cnt_d = sq_cnt_q + 4'd1;
                end
            end
            DONE: begin
                sq_state_d = IDLE;
            end
            default: begin
                sq_state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Incremental radius: (d+1)^2 = d^2 + (2d+1). dx/dy are 11-bit two's
    // complement; {d, 1'b1} is exactly 2d+1 as a 12-bit signed value, which
    // is sign-extended to 21 bits. The running squares stay non-negative, so
    // modulo-2^21 addition gives the exact result.
    // -----------------------------------------------------------------------
    logic [10:0] dx_q, dx_d;
    logic [10:0] dy_q, dy_d;
    logic [20:0] dx2_q, dx2_d;
    logic [20:0] dy2_q, dy2_d;
    logic [20:0] dx_step;
    logic [20:0] dy_step;

    assign dx_step = {{9{dx_q[10]}}, dx_q, 1'b1};
    assign dy_step = {{9{dy_q[10]}}, dy_q, 1'b1};

    always_comb begin
        dx_d  = dx_q;
        dx2_d = dx2_q;
        dy_d  = dy_q;
        dy2_d = dy2_q;
        if (h_last) begin
            // The next pixel is column 0, so reload dx = -cxl.
            dx2_d = {1'b0, cx2_q};
            dx_d  = 11'd0 - {1'b0, cxl_q};
            if (v_last) begin
                dy2_d = {1'b0, cy2_q};
                dy_d  = 11'd0 - {1'b0, cyl_q};
            end else begin
                dy2_d = dy2_q + dy_step;
                dy_d  = dy_q + 11'd1;
            end
        end else begin
            dx2_d = dx2_q + dx_step;
            dx_d  = dx_q + 11'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sq_state_q <= IDLE;
            cxl_q      <= '0;
            cyl_q      <= '0;
            cx2_q      <= '0;
            cy2_q      <= '0;
            sq_acc_q   <= '0;
            sq_cnt_q   <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            dx2_q      <= '0;
            dy2_q      <= '0;
        end else begin
            sq_state_q <= sq_state_d;
            cxl_q      <= cxl_d;
            cyl_q      <= cyl_d;
            cx2_q      <= cx2_d;
            cy2_q      <= cy2_d;
            sq_acc_q   <= sq_acc_d;
            sq_cnt_q   <= sq_cnt_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            dx2_q      <= dx2_d;
            dy2_q      <= dy2_d;
        end
    end

    assign r2_o = display_on_o ? (dx2_q + dy2_q) : 21'd0;
`else
    // Radius logic not built: centre inputs are intentionally ignored.
    logic unused_centre;
    assign unused_centre = ^{cx_i, cy_i};
    assign r2_o          = '0;
`endif

endmodule

// File: tb/tb_vga_timing_radius_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_radius_gen
//
// Runs the generator with a reduced raster (24x19 total, 16x12 visible,
// 3-bit frame counter) so that several frames and a frame-counter wrap fit
// in a few thousand cycles. The expected pixels are pushed into a scoreboard
// queue. A monitor pops each entry when the DUT reaches that
// (frame, hpos, vpos) and then compares every output.
//
// Reduced geometry:
//   H: visible 0..15, front 16..17, sync 18..21, back 22..23
//   V: visible 0..11, front 12..13, sync 14..15, back 16..18
//   centre latch at (0,12); 456 clocks per frame
// ---------------------------------------------------------------------------
module tb_vga_timing_radius_gen;

    localparam int HT         = 24;
    localparam int VT         = 19;
    localparam int FRAME_CLKS = HT * VT;
    localparam int BUDGET     = 6000;

`ifdef VGA_TIMING_RADIUS_EN
    localparam bit RAD = 1'b1;
`else
    localparam bit RAD = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [9:0]  cx;
    logic [9:0]  cy;
    logic        hsync;
    logic        vsync;
    logic        display_on;
    logic [9:0]  hpos;
    logic [9:0]  vpos;
    logic        line_start;
    logic        frame_start;
    logic [2:0]  frame;
    logic [20:0] r2;

    vga_timing_radius_gen #(
        .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
        .V_DISPLAY(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .FRAME_W(3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cx_i         (cx),
        .cy_i         (cy),
        .hsync_o      (hsync),
        .vsync_o      (vsync),
        .display_on_o (display_on),
        .hpos_o       (hpos),
        .vpos_o       (vpos),
        .line_start_o (line_start),
        .frame_start_o(frame_start),
        .frame_o      (frame),
        .r2_o         (r2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit meas_go = 1'b0;
    bit meas_done = 1'b0;

    typedef struct {
        string name;
        int f, h, v;
        int de, hs, vs, ls, fs, r2;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input string name, input int f, input int h, input int v,
                        input int de, input int hs, input int vs,
                        input int ls, input int fs, input int r2v);
        exp_t e;
        e.name = name; e.f = f; e.h = h; e.v = v;
        e.de = de; e.hs = hs; e.vs = vs; e.ls = ls; e.fs = fs;
        e.r2 = RAD ? r2v : 0;
        sb.push_back(e);
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".hpos"},  int'(hpos), 0);
        check({tag, ".vpos"},  int'(vpos), 0);
        check({tag, ".frame"}, int'(frame), 0);
        check({tag, ".de"},    int'(display_on), 1);
        check({tag, ".hs"},    int'(hsync), 1);
        check({tag, ".vs"},    int'(vsync), 1);
        check({tag, ".ls"},    int'(line_start), 1);
        check({tag, ".fs"},    int'(frame_start), 1);
        check({tag, ".r2"},    int'(r2), 0);
    endtask

    task automatic wait_pos(input int f, input int h, input int v);
        int n;
        n = 0;
        while (!(int'(frame) == f && int'(hpos) == h && int'(vpos) == v) && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (n >= BUDGET) begin
            checks++;
            errors++;
            $display("FAIL wait_pos: never reached f=%0d (%0d,%0d), now f=%0d (%0d,%0d)",
                     f, h, v, frame, hpos, vpos);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sb_timeout: %0d entries left, head %s needs f=%0d (%0d,%0d)",
                     sb.size(), sb[0].name, sb[0].f, sb[0].h, sb[0].v);
            sb.delete();
        end
    endtask

    // Scoreboard monitor: compares the head entry when its pixel comes up.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            if (int'(frame) == sb[0].f && int'(hpos) == sb[0].h && int'(vpos) == sb[0].v) begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, ".de"}, int'(display_on), e.de);
                check({e.name, ".hs"}, int'(hsync), e.hs);
                check({e.name, ".vs"}, int'(vsync), e.vs);
                check({e.name, ".ls"}, int'(line_start), e.ls);
                check({e.name, ".fs"}, int'(frame_start), e.fs);
                check({e.name, ".r2"}, int'(r2), e.r2);
                $display("[%0t] pixel %s f=%0d (%0d,%0d) r2=%0d exp=%0d",
                         $time, e.name, e.f, e.h, e.v, r2, e.r2);
            end
        end
    end

    // Whole-frame timing measurement over the first two frames after reset.
    initial begin : timing_mon
        wait (meas_go);
        @(negedge clk);
        for (int f = 0; f < 2; f++) begin
            int ls_n, ls_bad, fs_n, fs_bad, hs_bad, hs_run, hs_start, vs_lines, vs_first;
            ls_n = 0; ls_bad = 0; fs_n = 0; fs_bad = 0; hs_bad = 0;
            hs_run = 0; hs_start = -1; vs_lines = 0; vs_first = -1;
            check($sformatf("frame%0d.start_count", f), int'(frame), f);
            for (int k = 0; k < FRAME_CLKS; k++) begin
                if (line_start) begin
                    ls_n++;
                    if (hpos != 10'd0) ls_bad++;
                end
                if (frame_start) begin
                    fs_n++;
                    if (hpos != 10'd0 || vpos != 10'd0) fs_bad++;
                end
                if (!hsync) begin
                    if (hs_run == 0) hs_start = int'(hpos);
                    hs_run++;
                end
                if (hpos == 10'd0 && !vsync) begin
                    if (vs_lines == 0) vs_first = int'(vpos);
                    vs_lines++;
                end
                if (int'(hpos) == HT - 1) begin
                    if (hs_run != 4 || hs_start != 18) hs_bad++;
                    hs_run = 0;
                    hs_start = -1;
                end
                @(negedge clk);
            end
            check($sformatf("frame%0d.line_starts", f), ls_n, VT);
            check($sformatf("frame%0d.line_start_pos", f), ls_bad, 0);
            check($sformatf("frame%0d.frame_starts", f), fs_n, 1);
            check($sformatf("frame%0d.frame_start_pos", f), fs_bad, 0);
            check($sformatf("frame%0d.bad_hsync_lines", f), hs_bad, 0);
            check($sformatf("frame%0d.vsync_lines", f), vs_lines, 2);
            check($sformatf("frame%0d.vsync_first", f), vs_first, 14);
            check($sformatf("frame%0d.end_hpos", f), int'(hpos), 0);
            check($sformatf("frame%0d.end_vpos", f), int'(vpos), 0);
            check($sformatf("frame%0d.end_count", f), int'(frame), f + 1);
            $display("[%0t] frame %0d measured: line_starts=%0d hsync_bad=%0d vsync_lines=%0d",
                     $time, f, ls_n, hs_bad, vs_lines);
        end
        meas_done = 1'b1;
    end

    initial begin : stimulus
        int n;
        rst_n = 1'b1;
        cx    = 10'd8;
        cy    = 10'd6;
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("por");

        // Frame 0 uses the reset centre (0,0).
        //    name          f   h   v  de hs vs ls fs r2
        push("f0_origin",    0,  0,  0, 1, 1, 1, 1, 1, 0);
        push("f0_3_4",       0,  3,  4, 1, 1, 1, 0, 0, 25);
        push("f0_front",     0, 17,  4, 0, 1, 1, 0, 0, 0);
        push("f0_hs_first",  0, 18,  4, 0, 0, 1, 0, 0, 0);
        push("f0_hs_last",   0, 21,  4, 0, 0, 1, 0, 0, 0);
        push("f0_back",      0, 22,  4, 0, 1, 1, 0, 0, 0);
        push("f0_last_vis",  0, 15, 11, 1, 1, 1, 0, 0, 346);
        push("f0_past_vis",  0, 16, 11, 0, 1, 1, 0, 0, 0);
        push("f0_vfront",    0,  0, 13, 0, 1, 1, 1, 0, 0);
        push("f0_vs_first",  0,  0, 14, 0, 1, 0, 1, 0, 0);
        push("f0_vs_last",   0, 23, 15, 0, 1, 0, 0, 0, 0);
        push("f0_vback",     0,  0, 16, 0, 1, 1, 1, 0, 0);
        // Frame 1: centre (8,6) latched during frame 0 vblank.
        push("f1_origin",    1,  0,  0, 1, 1, 1, 1, 1, 100);
        push("f1_7_5",       1,  7,  5, 1, 1, 1, 0, 0, 2);
        push("f1_centre",    1,  8,  6, 1, 1, 1, 0, 0, 0);
        push("f1_9_6",       1,  9,  6, 1, 1, 1, 0, 0, 1);
        push("f1_blank_r2",  1, 16,  6, 0, 1, 1, 0, 0, 0);
        // cx changes to 3 at line 8; the rest of frame 1 stays on (8,6).
        push("f1_3_9",       1,  3,  9, 1, 1, 1, 0, 0, 34);
        push("f1_8_9",       1,  8,  9, 1, 1, 1, 0, 0, 9);
        // Frame 2: centre (3,6).
        push("f2_origin",    2,  0,  0, 1, 1, 1, 1, 1, 45);
        push("f2_centre",    2,  3,  6, 1, 1, 1, 0, 0, 0);
        push("f2_4_6",       2,  4,  6, 1, 1, 1, 0, 0, 1);
        // Frame 3: centre (1023,1023), largest distances.
        push("f3_origin",    3,  0,  0, 1, 1, 1, 1, 1, 2093058);
        push("f3_last_vis",  3, 15, 11, 1, 1, 1, 0, 0, 2040208);
        push("f3_past_vis",  3, 16, 11, 0, 1, 1, 0, 0, 0);

        @(posedge clk);
        #2 rst_n = 1'b1;
        meas_go = 1'b1;

        wait_pos(1, 0, 8);
        cx = 10'd3;
        wait_pos(2, 0, 8);
        cx = 10'd1023;
        cy = 10'd1023;
        wait_drain();

        // Frame counter wraps 7 -> 0.
        push("f7_origin",    7,  0,  0, 1, 1, 1, 1, 1, 2093058);
        push("wrap_origin",  0,  0,  0, 1, 1, 1, 1, 1, 2093058);
        wait_drain();

        n = 0;
        while (!meas_done && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("meas_done", int'(meas_done), 1);

        // Reset in the middle of a frame.
        wait_pos(1, 10, 7);
        rst_n = 1'b0;
        #1 check_reset("mid_assert");
        repeat (3) @(posedge clk);
        #1 check_reset("mid_hold");
        push("rst_0_1",      0,  0,  1, 1, 1, 1, 1, 0, 1);
        push("rst_3_4",      0,  3,  4, 1, 1, 1, 0, 0, 25);
        push("rst_f1_origin",1,  0,  0, 1, 1, 1, 1, 1, 2093058);
        #1 rst_n = 1'b1;
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
